// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops,
// iterative 1-bit/cycle SLL/SRL with start/busy/done.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b1111;
  localparam logic [3:0] OP_SRL = 4'b1110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       cnt_q;
  logic             left_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] shreg_d;
  logic             is_shift;

  // shift ops with shamt=0 resolve here in one cycle
  always_comb begin
    alu_d = '0;
    unique case (ALUOperation)
      OP_AND:  alu_d = A & B;
      OP_OR:   alu_d = A | B;
      OP_NOR:  alu_d = ~(A | B);
      OP_ADD:  alu_d = A + B;
      OP_SUB:  alu_d = A - B;
      OP_LUI:  alu_d = WIDTH'(B[15:0]) << 16;
      OP_SLL:  alu_d = B << shamt;
      OP_SRL:  alu_d = B >> shamt;
      default: alu_d = '0;
    endcase
  end

  assign is_shift = (ALUOperation == OP_SLL) ||
                    (ALUOperation == OP_SRL);

  assign shreg_d = left_q ? (shreg_q << 1)
                          : (shreg_q >> 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_shift && shamt != 5'd0) begin
              shreg_q <= B;
              cnt_q   <= shamt;
              left_q  <= (ALUOperation == OP_SLL);
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end else begin
              res_q  <= alu_d;
              zero_q <= (alu_d == '0);
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            res_q   <= shreg_d;
            zero_q  <= (shreg_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Inputs change at negedge, outputs sampled 1ns after posedge.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks;
  int errors;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .shamt        (shamt),
    .busy         (busy),
    .done         (done),
    .ALUResult    (ALUResult),
    .Zero         (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // present a request for one edge (E0); returns 1ns after E0
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    ALUOperation = op;
    A = a;
    B = b;
    shamt = sh;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        ALUResult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b res=%h zero=%b want 0 0 0 1",
               busy, done, ALUResult, Zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sub_add_zero;
    issue(4'b0100, 32'h12345678, 32'h12345678, 5'd0);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: done=%b res=%h zero=%b want 1 00000000 1",
               done, ALUResult, Zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL sub_done_pulse: done=%b want 0", done);
    end
    issue(4'b0011, 32'hFFFFFFFF, 32'h1, 5'd0);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: done=%b res=%h zero=%b want 1 00000000 1",
               done, ALUResult, Zero);
    end
  endtask

  task automatic test_lui_nor;
    issue(4'b0101, 32'h0, 32'h0000ABCD, 5'd0);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'hABCD0000 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL lui: done=%b res=%h zero=%b want 1 abcd0000 0",
               done, ALUResult, Zero);
    end
    issue(4'b0010, 32'h0, 32'h0, 5'd0);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'hFFFFFFFF || Zero !== 1'b0) begin
      errors++;
      $display("FAIL nor: done=%b res=%h zero=%b want 1 ffffffff 0",
               done, ALUResult, Zero);
    end
    issue(4'b1001, 32'h5, 32'h7, 5'd3);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL undef_op: done=%b res=%h zero=%b want 1 00000000 1",
               done, ALUResult, Zero);
    end
    issue(4'b0100, 32'h5, 32'h7, 5'd0);
    checks++;
    if (ALUResult !== 32'hFFFFFFFE || Zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: res=%h zero=%b want fffffffe 0",
               ALUResult, Zero);
    end
  endtask

  task automatic test_sll_multi;
    int n;
    int dones;
    logic [31:0] prev;
    prev = ALUResult;
    issue(4'b1111, 32'h0, 32'h00000001, 5'd4);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || ALUResult !== prev) begin
      errors++;
      $display("FAIL sll_e0: busy=%b done=%b res=%h want 1 0 %h",
               busy, done, ALUResult, prev);
    end
    // ignored request while busy, with changed operands
    ALUOperation = 4'b0011;
    A = 32'h1;
    B = 32'h1;
    shamt = 5'd0;
    start = 1'b1;
    n = 0;
    dones = 0;
    while (n < 40 && dones == 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done === 1'b1) dones++;
      else begin
        checks++;
        if (busy !== 1'b1 || ALUResult !== prev) begin
          errors++;
          $display("FAIL sll_hold: cyc=%0d busy=%b res=%h want 1 %h",
                   n, busy, ALUResult, prev);
        end
      end
    end
    checks++;
    if (n != 4 || busy !== 1'b0 || ALUResult !== 32'h10 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL sll_done: cycles=%0d busy=%b res=%h want 4 0 00000010",
               n, busy, ALUResult);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || ALUResult !== 32'h10) begin
      errors++;
      $display("FAIL sll_no_extra: dones=%0d res=%h want 1 00000010",
               dones, ALUResult);
    end
  endtask

  task automatic test_srl_extremes;
    int n;
    issue(4'b1110, 32'h0, 32'h80000000, 5'd31);
    n = 0;
    while (n < 40 && done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 31 || done !== 1'b1 || ALUResult !== 32'h1 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL srl31: cycles=%0d done=%b res=%h want 31 1 00000001",
               n, done, ALUResult);
    end
    issue(4'b1110, 32'h0, 32'hDEADBEEF, 5'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ALUResult !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL srl0: done=%b busy=%b res=%h want 1 0 deadbeef",
               done, busy, ALUResult);
    end
    issue(4'b1111, 32'h0, 32'h80000001, 5'd1);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'h00000002) begin
      errors++;
      $display("FAIL sll1: done=%b res=%h want 1 00000002",
               done, ALUResult);
    end
  endtask

  task automatic test_reset_mid_shift;
    int dones;
    issue(4'b1111, 32'h0, 32'h00000001, 5'd20);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        ALUResult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b res=%h zero=%b want 0 0 0 1",
               busy, done, ALUResult, Zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || ALUResult !== 32'h0) begin
      errors++;
      $display("FAIL discarded: activity=%0d res=%h want 0 00000000",
               dones, ALUResult);
    end
    issue(4'b0011, 32'd2, 32'd3, 5'd0);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'd5 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: done=%b res=%h want 1 00000005",
               done, ALUResult);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    ALUOperation = 4'b0000;
    A = 32'h0000F0F0;
    B = 32'h0000FF00;
    shamt = 5'd0;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'h0000F000) begin
      errors++;
      $display("FAIL b2b_and: done=%b res=%h want 1 0000f000",
               done, ALUResult);
    end
    ALUOperation = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'h0000FFF0) begin
      errors++;
      $display("FAIL b2b_or: done=%b res=%h want 1 0000fff0",
               done, ALUResult);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || ALUResult !== 32'h0000FFF0) begin
      errors++;
      $display("FAIL b2b_idle: done=%b res=%h want 0 0000fff0",
               done, ALUResult);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    ALUOperation = 4'b0000;
    A = '0;
    B = '0;
    shamt = '0;
    #3;
    test_reset;
    test_sub_add_zero;
    test_lui_nor;
    test_sll_multi;
    test_srl_extremes;
    test_reset_mid_shift;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
